// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int FRAME_BITS         = 11;
    localparam int DATA_BITS          = 8;
    localparam int DEFAULT_CLK_HZ     = 25_000_000;
    localparam int DEFAULT_TIMEOUT_US = 200;

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO with a registered head word, so every output
// comes straight from a flop.
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;

    logic             w_doPop;
    logic             w_doPush;
    logic [AW-1:0]    w_rdPtrNext;
    logic [CW-1:0]    w_countNext;
    logic [WIDTH-1:0] w_headNext;

    assign w_doPop     = i_pop & ~o_empty;
    assign w_doPush    = i_push & (~o_full | w_doPop);
    assign w_rdPtrNext = w_doPop ? r_rdPtr + AW'(1) : r_rdPtr;

    // The next head is the slot the read pointer lands on, bypassing the
    // write data when that very slot is being filled this cycle.
    always_comb begin
        w_countNext = o_count;
        if (w_doPush && !w_doPop)
            w_countNext = o_count + CW'(1);
        else if (w_doPop && !w_doPush)
            w_countNext = o_count - CW'(1);

        w_headNext = '0;
        if (w_countNext != '0) begin
            if (w_doPush && (r_wrPtr == w_rdPtrNext))
                w_headNext = i_wdata;
            else
                w_headNext = r_mem[w_rdPtrNext];
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush)
            r_mem[r_wrPtr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            o_count <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
            o_rdata <= '0;
        end else begin
            if (w_doPush)
                r_wrPtr <= r_wrPtr + AW'(1);
            r_rdPtr <= w_rdPtrNext;
            o_count <= w_countNext;
            o_empty <= (w_countNext == '0);
            o_full  <= (w_countNext == CW'(DEPTH));
            o_rdata <= w_headNext;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, deglitch the clock, decode
// 11-bit frames and queue good bytes for the CPU with sticky error status.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int TIMEOUT_US = DEFAULT_TIMEOUT_US,
    parameter int FILTER_LEN = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          int_clear,
    output logic [7:0]                    data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          irq
);

    localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int BW = $clog2(FRAME_BITS);

    logic [1:0]     r_clkSync;
    logic [1:0]     r_dataSync;
    logic           r_filt;
    logic           r_filtD;
    logic [FW-1:0]  r_filtCnt;
    ps2_state_t     r_state;
    ps2_state_t     w_stateNext;
    logic [BW-1:0]  r_bitCnt;
    logic [7:0]     r_shift;
    logic           r_parity;
    logic [TW-1:0]  r_toCnt;
    logic           r_pushD;
    logic           r_errSetD;

    logic           w_fall;
    logic           w_bit;
    logic           w_pop;
    logic           w_timeout;
    logic           w_shiftEn;
    logic           w_capPar;
    logic           w_push;
    logic           w_setPar;
    logic           w_setFrame;
    logic           w_setOvf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk};
            r_dataSync <= {r_dataSync[0], ps2_data};
        end
    end

    // Any sample that matches the current level restarts the run count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt    <= 1'b1;
            r_filtD   <= 1'b1;
            r_filtCnt <= '0;
        end else begin
            r_filtD <= r_filt;
            if (r_clkSync[1] == r_filt) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == FW'(FILTER_LEN - 1)) begin
                r_filt    <= r_clkSync[1];
                r_filtCnt <= '0;
            end else begin
                r_filtCnt <= r_filtCnt + FW'(1);
            end
        end
    end

    assign w_fall    = r_filtD & ~r_filt;
    assign w_bit     = r_dataSync[1];
    assign w_pop     = rd_en & ~empty;
    assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                       (r_toCnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_stateNext = r_state;
        w_shiftEn   = 1'b0;
        w_capPar    = 1'b0;
        w_push      = 1'b0;
        w_setPar    = 1'b0;
        w_setFrame  = 1'b0;
        w_setOvf    = 1'b0;
        if (w_timeout) begin
            w_stateNext = ST_IDLE;
            w_setFrame  = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_bit)
                        w_stateNext = ST_DATA;
                end
                ST_DATA: begin
                    w_shiftEn = 1'b1;
                    if (r_bitCnt == BW'(DATA_BITS - 1))
                        w_stateNext = ST_PARITY;
                end
                ST_PARITY: begin
                    w_capPar    = 1'b1;
                    w_stateNext = ST_STOP;
                end
                ST_STOP: begin
                    w_stateNext = ST_IDLE;
                    if (!w_bit)
                        w_setFrame = 1'b1;
                    else if (~^{r_shift, r_parity})
                        w_setPar = 1'b1;
                    else if (full && !w_pop)
                        w_setOvf = 1'b1;
                    else
                        w_push = 1'b1;
                end
                default: w_stateNext = ST_IDLE;
            endcase
        end
    end

    // Bits arrive LSB first, so they enter at the top and shift down.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_toCnt  <= '0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == ST_IDLE)
                r_bitCnt <= '0;
            else if (w_shiftEn)
                r_bitCnt <= r_bitCnt + BW'(1);
            if (w_shiftEn)
                r_shift <= {w_bit, r_shift[7:1]};
            if (w_capPar)
                r_parity <= w_bit;
            if (r_state == ST_IDLE || w_fall)
                r_toCnt <= '0;
            else
                r_toCnt <= r_toCnt + TW'(1);
        end
    end

    // A set event outranks a simultaneous clear for both flags and irq.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pushD    <= 1'b0;
            r_errSetD  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            r_pushD    <= w_push;
            r_errSetD  <= w_setPar | w_setFrame | w_setOvf;
            parity_err <= w_setPar   | (parity_err & ~int_clear);
            frame_err  <= w_setFrame | (frame_err  & ~int_clear);
            overflow   <= w_setOvf   | (overflow   & ~int_clear);
            irq        <= r_pushD | r_errSetD | (irq & ~int_clear);
        end
    end

    ps2_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (r_shift),
        .i_pop   (w_pop),
        .o_rdata (data),
        .o_empty (empty),
        .o_full  (full),
        .o_count (count)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo with a 1 MHz system clock so a 10 kHz PS/2
// bit is 100 cycles and the 200 us timeout is 200 cycles.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       int_clear;
    logic [7:0] data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       irq;

    int nChecks = 0;
    int nFails  = 0;

    ps2_rx_fifo #(
        .CLK_HZ     (1_000_000),
        .TIMEOUT_US (200),
        .FILTER_LEN (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .int_clear  (int_clear),
        .data       (data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // The filtered fall lands 6 cycles after the raw fall; popAtFall holds
    // rd_en for exactly that cycle.
    task automatic sendBit(input logic b, input logic popAtFall);
        ps2_data = b;
        repeat (25) tick();
        ps2_clk = 1'b0;
        if (popAtFall) begin
            repeat (6) tick();
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            repeat (43) tick();
        end else begin
            repeat (50) tick();
        end
        ps2_clk = 1'b1;
        repeat (25) tick();
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic badPar, input logic stopBit,
                                 input int nBits, input int glitchAt, input logic popAtStop);
        logic [10:0] frame;
        frame = {stopBit, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            if (i == glitchAt) begin
                ps2_clk = 1'b0;
                tick();
                tick();
                ps2_clk = 1'b1;
                repeat (10) tick();
            end
            sendBit(frame[i], popAtStop && (i == 10));
        end
        ps2_data = 1'b1;
    endtask

    task automatic popOne();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic clearInt();
        int_clear = 1'b1;
        tick();
        int_clear = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        rd_en     = 1'b0;
        int_clear = 1'b0;
        repeat (3) tick();
        checkOutput("rst_data", 32'(data), 32'h0);
        checkOutput("rst_empty", 32'(empty), 32'h1);
        checkOutput("rst_full", 32'(full), 32'h0);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_flags", 32'({parity_err, frame_err, overflow}), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        repeat (5) tick();

        $display("[TB] good frame 0x1C");
        applyStimulus(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0);
        checkOutput("g_data", 32'(data), 32'h1C);
        checkOutput("g_count", 32'(count), 32'h1);
        checkOutput("g_irq", 32'(irq), 32'h1);
        checkOutput("g_flags", 32'({parity_err, frame_err, overflow}), 32'h0);
        popOne();
        checkOutput("g_pop_empty", 32'(empty), 32'h1);
        checkOutput("g_pop_data", 32'(data), 32'h0);
        checkOutput("g_irq_sticky", 32'(irq), 32'h1);
        clearInt();
        checkOutput("g_irq_clr", 32'(irq), 32'h0);

        $display("[TB] parity error then 0xF0");
        applyStimulus(8'h1C, 1'b1, 1'b1, 11, -1, 1'b0);
        checkOutput("p_perr", 32'(parity_err), 32'h1);
        checkOutput("p_irq", 32'(irq), 32'h1);
        checkOutput("p_empty", 32'(empty), 32'h1);
        applyStimulus(8'hF0, 1'b0, 1'b1, 11, -1, 1'b0);
        checkOutput("p_f0_data", 32'(data), 32'hF0);
        popOne();
        clearInt();
        checkOutput("p_clr", 32'({parity_err, irq}), 32'h0);

        $display("[TB] overflow");
        for (int i = 1; i <= 9; i++)
            applyStimulus(8'(i), 1'b0, 1'b1, 11, -1, 1'b0);
        checkOutput("o_full", 32'(full), 32'h1);
        checkOutput("o_count", 32'(count), 32'h8);
        checkOutput("o_ovf", 32'(overflow), 32'h1);
        checkOutput("o_head", 32'(data), 32'h01);
        clearInt();
        checkOutput("o_ovf_clr", 32'({overflow, irq}), 32'h0);
        applyStimulus(8'h0A, 1'b0, 1'b1, 11, -1, 1'b1);
        checkOutput("o_pp_count", 32'(count), 32'h8);
        checkOutput("o_pp_ovf", 32'(overflow), 32'h0);
        checkOutput("o_pp_irq", 32'(irq), 32'h1);
        for (int i = 2; i <= 8; i++) begin
            checkOutput("o_drain", 32'(data), 32'(i));
            popOne();
        end
        checkOutput("o_drain_last", 32'(data), 32'h0A);
        popOne();
        checkOutput("o_drained", 32'(empty), 32'h1);
        clearInt();

        $display("[TB] timeout");
        applyStimulus(8'h00, 1'b0, 1'b1, 5, -1, 1'b0);
        repeat (300) tick();
        checkOutput("t_ferr", 32'(frame_err), 32'h1);
        checkOutput("t_state", 32'(dut.r_state), 32'(ST_IDLE));
        checkOutput("t_empty", 32'(empty), 32'h1);
        clearInt();
        applyStimulus(8'h5A, 1'b0, 1'b1, 11, -1, 1'b0);
        checkOutput("t_5a_data", 32'(data), 32'h5A);
        checkOutput("t_5a_flags", 32'({parity_err, frame_err, overflow}), 32'h0);
        popOne();
        clearInt();

        $display("[TB] glitches");
        ps2_clk = 1'b0;
        tick();
        tick();
        ps2_clk = 1'b1;
        repeat (20) tick();
        checkOutput("gl_idle_state", 32'(dut.r_state), 32'(ST_IDLE));
        checkOutput("gl_idle_out", 32'({empty, irq, parity_err, frame_err, overflow}), 32'h10);
        applyStimulus(8'hA5, 1'b0, 1'b1, 11, 4, 1'b0);
        checkOutput("gl_frame_data", 32'(data), 32'hA5);
        checkOutput("gl_frame_flags", 32'({parity_err, frame_err, overflow}), 32'h0);
        popOne();
        clearInt();

        $display("[TB] reset mid-frame");
        applyStimulus(8'h11, 1'b0, 1'b1, 11, -1, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b1, 11, -1, 1'b0);
        applyStimulus(8'h33, 1'b0, 1'b1, 11, -1, 1'b0);
        checkOutput("r_count3", 32'(count), 32'h3);
        applyStimulus(8'h44, 1'b0, 1'b1, 5, -1, 1'b0);
        reset_n = 1'b0;
        repeat (3) tick();
        checkOutput("r_out", 32'({data, empty, full, count, parity_err, frame_err, overflow, irq}),
                    32'({8'h00, 1'b1, 1'b0, 4'h0, 4'h0}));
        checkOutput("r_state", 32'(dut.r_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        repeat (5) tick();
        applyStimulus(8'h44, 1'b0, 1'b1, 11, -1, 1'b0);
        checkOutput("r_44_data", 32'(data), 32'h44);
        checkOutput("r_44_count", 32'(count), 32'h1);
        checkOutput("r_44_flags", 32'({parity_err, frame_err, overflow}), 32'h0);
        popOne();
        clearInt();

        $display("[TB] bad stop bit");
        applyStimulus(8'h33, 1'b0, 1'b0, 11, -1, 1'b0);
        repeat (10) tick();
        checkOutput("s_ferr", 32'(frame_err), 32'h1);
        checkOutput("s_perr", 32'(parity_err), 32'h0);
        checkOutput("s_empty", 32'(empty), 32'h1);
        checkOutput("s_irq", 32'(irq), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
